simon_key_schedule: RTL and testbench

Upstream key-expansion stage for the Simon round datapath. Accepts a master key over a valid/ready handshake and expands it into T round keys, one per cycle. It stores the keys in a register array and serves them through a registered random-access read port, so the encrypt/decrypt engine can index rounds forward (k[r]) or backward (k[T-1-r]). The engine must not start until `keys_valid` is high.

---
 rtl/simon_pkg.sv | 49 ++++
 rtl/simon_key_schedule_round.sv | 28 ++
 rtl/simon_key_schedule.sv | 145 ++++++++++++++
 tb/tb_simon_key_schedule.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon key schedule: FSM states, z sequences,
// parameter legality check and a width-generic rotate-right helper.
package simon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GEN   = 2'd1,
    ST_READY = 2'd2
  } ks_state_e;

  // z_j[0] sits at bit 61, so sequence element idx is z[61-idx].
  localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

  function automatic logic [61:0] z_seq(input int j);
    case (j)
      0:       return Z0;
      1:       return Z1;
      2:       return Z2;
      3:       return Z3;
      default: return Z4;
    endcase
  endfunction

  // Word size / key-word combinations defined by the Simon family.
  function automatic bit simon_params_ok(input int n, input int m, input int t, input int j);
    bit nm_ok;
    case (n)
      16:      nm_ok = (m == 4);
      24, 32:  nm_ok = (m == 3) || (m == 4);
      48:      nm_ok = (m == 2) || (m == 3);
      64:      nm_ok = (m >= 2) && (m <= 4);
      default: nm_ok = 1'b0;
    endcase
    return nm_ok && (j >= 0) && (j <= 4) && (t > m) && (t <= 255);
  endfunction

  function automatic logic [63:0] ror_n(input logic [63:0] x, input int r, input int n);
    logic [63:0] mask;
    logic [63:0] xm;
    mask = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    xm   = x & mask;
    return ((xm >> r) | (xm << (n - r))) & mask;
  endfunction

endpackage

// File: rtl/simon_key_schedule_round.sv
// One Simon key-expansion step: derives k[i] from the three window taps
// and the current z-sequence bit. Purely combinational.
module simon_key_round
  import simon_pkg::*;
#(
  parameter int N = 16,
  parameter int M = 4
) (
  input  logic [N-1:0] k_im1,
  input  logic [N-1:0] k_im3,
  input  logic [N-1:0] k_imm,
  input  logic         z_bit,
  output logic [N-1:0] k_new
);

  logic [N-1:0] ror3;
  logic [N-1:0] mix;
  logic [N-1:0] tmp;

  always_comb begin
    ror3  = N'(ror_n(64'(k_im1), 3, N));
    // k[i-3] only joins the mix for four-word keys.
    mix   = (M == 4) ? (ror3 ^ k_im3) : ror3;
    tmp   = mix ^ N'(ror_n(64'(mix), 1, N));
    k_new = ~k_imm ^ tmp ^ N'(3) ^ {{(N-1){1'b0}}, z_bit};
  end

endmodule

// File: rtl/simon_key_schedule.sv
// Simon key schedule: accepts a master key, expands T round keys one per
// cycle into a register array, and serves them through a registered read port.
module simon_key_schedule
  import simon_pkg::*;
#(
  parameter int N  = 16,
  parameter int M  = 4,
  parameter int T  = 32,
  parameter int J  = 0,
  parameter int AW = $clog2(T)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_valid,
  output logic           key_ready,
  input  logic [M*N-1:0] key,
  output logic           busy,
  output logic           keys_valid,
  input  logic           rk_rd,
  input  logic [AW-1:0]  rk_addr,
  output logic [N-1:0]   rk_data
);

  localparam int          MW        = $clog2(T);
  localparam int          IM3       = (M >= 3) ? M - 3 : 0;
  localparam logic [61:0] Z_CONST   = z_seq(J);
  localparam logic [7:0]  LAST_IDX  = 8'(T - 1);
  localparam logic [7:0]  FIRST_IDX = 8'(M);

  if (!simon_params_ok(N, M, T, J) || ((2 ** AW) < T)) begin : g_bad_params
    $error("simon_key_schedule: illegal parameter set");
  end

  ks_state_e    state_q, state_d;
  logic [7:0]   idx_q, idx_d;
  logic [5:0]   z_idx_q, z_idx_d;
  logic         keys_valid_q, keys_valid_d;
  logic [N-1:0] rk_data_q, rk_data_d;
  logic [N-1:0] win_q [M];
  logic [N-1:0] win_d [M];
  logic [N-1:0] key_words [M];
  logic [N-1:0] key_mem [T];
  logic [N-1:0] k_new;
  logic [MW-1:0] rd_idx;
  logic         accept;
  logic         gen_wr;
  logic         z_bit;

  genvar gi;
  for (gi = 0; gi < M; gi++) begin : g_key_words
    assign key_words[gi] = key[gi*N +: N];
  end

  assign rd_idx = rk_addr[MW-1:0];
  assign z_bit  = Z_CONST[6'd61 - z_idx_q];

  // Window layout: win[0] = k[i-M] (oldest) ... win[M-1] = k[i-1] (newest).
  simon_key_round #(
    .N (N),
    .M (M)
  ) u_round (
    .k_im1 (win_q[M-1]),
    .k_im3 (win_q[IM3]),
    .k_imm (win_q[0]),
    .z_bit (z_bit),
    .k_new (k_new)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    z_idx_d      = z_idx_q;
    keys_valid_d = keys_valid_q;
    win_d        = win_q;
    gen_wr       = 1'b0;
    accept       = key_valid && (state_q != ST_GEN);

    if (state_q == ST_GEN) begin
      gen_wr  = 1'b1;
      idx_d   = idx_q + 8'd1;
      z_idx_d = (z_idx_q == 6'd61) ? 6'd0 : z_idx_q + 6'd1;
      for (int w = 0; w < M - 1; w++) begin
        win_d[w] = win_q[w+1];
      end
      win_d[M-1] = k_new;
      if (idx_q == LAST_IDX) begin
        state_d      = ST_READY;
        keys_valid_d = 1'b1;
      end
    end

    // Accept is only possible outside GEN, so it never collides with a step.
    if (accept) begin
      win_d        = key_words;
      idx_d        = FIRST_IDX;
      z_idx_d      = 6'd0;
      keys_valid_d = 1'b0;
      state_d      = ST_GEN;
    end

    rk_data_d = rk_data_q;
    if (rk_rd) begin
      rk_data_d = (32'(rk_addr) < 32'(T)) ? key_mem[rd_idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= 8'd0;
      z_idx_q      <= 6'd0;
      keys_valid_q <= 1'b0;
      rk_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      z_idx_q      <= z_idx_d;
      keys_valid_q <= keys_valid_d;
      rk_data_q    <= rk_data_d;
    end
  end

  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  // Array is never cleared; reset only suppresses writes for that cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        for (int w = 0; w < M; w++) begin
          key_mem[w] <= key_words[w];
        end
      end else if (gen_wr) begin
        key_mem[idx_q[MW-1:0]] <= k_new;
      end
    end
  end

  assign key_ready  = (state_q != ST_GEN);
  assign busy       = (state_q == ST_GEN);
  assign keys_valid = keys_valid_q;
  assign rk_data    = rk_data_q;

endmodule

// File: tb/tb_simon_key_schedule.sv
// Scoreboard bench for simon_key_schedule: three parameter sets, random keys,
// array-based reference model, decoupled read-data monitor.
`timescale 1ns/1ps
module tb_simon_key_schedule;

  localparam int PN  [3] = '{16, 24, 48};
  localparam int PM  [3] = '{4, 3, 2};
  localparam int PT  [3] = '{32, 36, 72};
  localparam int PJ  [3] = '{0, 0, 2};
  localparam int PAW [3] = '{6, 6, 7};

  localparam logic [61:0] TZ0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] TZ2 = 62'b10101111011100000011010010011000101000010001111110010110110011;

  typedef struct {
    int          addr;
    logic [63:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  kvalid = '0;
  logic [2:0]  rd = '0;
  logic [2:0]  pend = '0;
  wire  [2:0]  kready, busy, kvo;
  logic [63:0] key0;
  logic [71:0] key1;
  logic [95:0] key2;
  logic [5:0]  addr0, addr1;
  logic [6:0]  addr2;
  wire  [15:0] rkd0;
  wire  [23:0] rkd1;
  wire  [47:0] rkd2;

  int errors = 0;
  int checks = 0;

  logic [63:0] mkey [3][4];
  logic [63:0] mk   [3][256];
  logic [15:0] cap0 [32];
  exp_t        sbq  [3][$];
  exp_t        mon_it;
  logic [63:0] mon_got;

  always #5 clk = ~clk;

  simon_key_schedule #(.N(16), .M(4), .T(32), .J(0), .AW(6)) dut0 (
    .clk(clk), .rst(rst), .key_valid(kvalid[0]), .key_ready(kready[0]), .key(key0),
    .busy(busy[0]), .keys_valid(kvo[0]), .rk_rd(rd[0]), .rk_addr(addr0), .rk_data(rkd0));

  simon_key_schedule #(.N(24), .M(3), .T(36), .J(0), .AW(6)) dut1 (
    .clk(clk), .rst(rst), .key_valid(kvalid[1]), .key_ready(kready[1]), .key(key1),
    .busy(busy[1]), .keys_valid(kvo[1]), .rk_rd(rd[1]), .rk_addr(addr1), .rk_data(rkd1));

  simon_key_schedule #(.N(48), .M(2), .T(72), .J(2), .AW(7)) dut2 (
    .clk(clk), .rst(rst), .key_valid(kvalid[2]), .key_ready(kready[2]), .key(key2),
    .busy(busy[2]), .keys_valid(kvo[2]), .rk_rd(rd[2]), .rk_addr(addr2), .rk_data(rkd2));

  function automatic logic [63:0] wmask(int n);
    return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

  function automatic logic [63:0] mror(logic [63:0] x, int r, int n);
    return ((x >> r) | (x << (n - r))) & wmask(n);
  endfunction

  function automatic logic zb(int j, int idx);
    logic [61:0] z;
    z = (j == 0) ? TZ0 : TZ2;
    return z[61 - idx];
  endfunction

  function automatic logic [15:0] rol16(logic [15:0] x, int s);
    return (x << s) | (x >> (16 - s));
  endfunction

  function automatic logic [63:0] get_rkd(int k);
    case (k)
      0:       return 64'(rkd0);
      1:       return 64'(rkd1);
      default: return 64'(rkd2);
    endcase
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expand the master key of instance k straight from the recurrence.
  task automatic build_model(int k);
    logic [63:0] tmp;
    int n, m;
    n = PN[k];
    m = PM[k];
    for (int i = 0; i < m; i++) mk[k][i] = mkey[k][i] & wmask(n);
    for (int i = m; i < PT[k]; i++) begin
      tmp = mror(mk[k][i-1], 3, n);
      if (m == 4) tmp = tmp ^ mk[k][i-3];
      tmp = tmp ^ mror(tmp, 1, n);
      mk[k][i] = (~mk[k][i-m] ^ tmp ^ 64'(zb(PJ[k], (i - m) % 62)) ^ 64'd3) & wmask(n);
    end
  endtask

  task automatic rand_key(int k);
    for (int w = 0; w < 4; w++) mkey[k][w] = {$urandom, $urandom} & wmask(PN[k]);
  endtask

  task automatic set_rd(int k, bit en, int a);
    rd[k] = en;
    case (k)
      0:       addr0 = 6'(a);
      1:       addr1 = 6'(a);
      default: addr2 = 7'(a);
    endcase
  endtask

  task automatic read_exp(int k, int a, logic [63:0] e);
    exp_t it;
    set_rd(k, 1'b1, a);
    it.addr = a;
    it.d    = e;
    sbq[k].push_back(it);
    tick();
  endtask

  task automatic rd_model(int k, int a);
    read_exp(k, a, (a < PT[k]) ? mk[k][a] : 64'd0);
  endtask

  task automatic rd_stop(int k);
    set_rd(k, 1'b0, 0);
    tick();
    tick();
  endtask

  task automatic offer(int k, bit hold);
    case (k)
      0:       key0 = {mkey[0][3][15:0], mkey[0][2][15:0], mkey[0][1][15:0], mkey[0][0][15:0]};
      1:       key1 = {mkey[1][2][23:0], mkey[1][1][23:0], mkey[1][0][23:0]};
      default: key2 = {mkey[2][1][47:0], mkey[2][0][47:0]};
    endcase
    build_model(k);
    kvalid[k] = 1'b1;
    tick();
    if (!hold) kvalid[k] = 1'b0;
    $display("key accepted inst%0d k0=%h", k, mkey[k][0]);
    chk("busy_after_accept", 64'(busy[k]), 64'd1);
    chk("ready_after_accept", 64'(kready[k]), 64'd0);
    chk("kv_after_accept", 64'(kvo[k]), 64'd0);
  endtask

  task automatic wait_kv(int k);
    int n;
    n = 0;
    while (!kvo[k] && n < 300) begin
      tick();
      n++;
    end
    kvalid[k] = 1'b0;
    chk("kv_latency", 64'(n + 1), 64'(PT[k] - PM[k] + 1));
  endtask

  task automatic sweep_fwd(int k);
    for (int a = 0; a < PT[k]; a++) rd_model(k, a);
    rd_model(k, PT[k]);
    rd_model(k, (1 << PAW[k]) - 1);
    rd_stop(k);
  endtask

  always @(posedge clk) pend <= rd;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (pend[k]) begin
        mon_got = get_rkd(k);
        if (sbq[k].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rk_unexpected inst%0d got=%h exp=none", k, mon_got);
        end else begin
          mon_it = sbq[k].pop_front();
          $display("read inst%0d addr=%0d data=%h", k, mon_it.addr, mon_got);
          chk($sformatf("rk_data inst%0d addr%0d", k, mon_it.addr), mon_got, mon_it.d);
          if (k == 0 && mon_it.addr < 32) cap0[mon_it.addr] = mon_got[15:0];
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [15:0] x, y, t;
    key0 = '0; key1 = '0; key2 = '0;
    addr0 = '0; addr1 = '0; addr2 = '0;
    rst = 1'b1;
    tick();
    tick();
    chk("reset_key_ready", 64'(kready[0]), 64'd1);
    chk("reset_busy", 64'(busy[0]), 64'd0);
    chk("reset_keys_valid", 64'(kvo[0]), 64'd0);
    chk("reset_rk_data", 64'(rkd0), 64'd0);
    rst = 1'b0;
    tick();

    // Simon32/64 vector, key_valid held through GEN with a changing key.
    mkey[0][0] = 64'h0100; mkey[0][1] = 64'h0908;
    mkey[0][2] = 64'h1110; mkey[0][3] = 64'h1918;
    offer(0, 1'b1);
    key0 = {$urandom, $urandom};
    wait_kv(0);
    read_exp(0, 4, 64'h71C3);
    for (int a = 31; a >= 0; a--) rd_model(0, a);
    rd_model(0, 32);
    rd_model(0, 63);
    rd_model(0, 7);
    rd_stop(0);
    tick();
    chk("rk_hold", 64'(rkd0), mk[0][7]);
    x = 16'h6565;
    y = 16'h6877;
    for (int r = 0; r < 32; r++) begin
      t = x;
      x = y ^ ((rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2)) ^ cap0[r];
      y = t;
    end
    chk("simon32_ct", 64'({x, y}), 64'hC69BE9BB);

    // Back-to-back rekey with an all-zero key.
    for (int w = 0; w < 4; w++) mkey[0][w] = 64'd0;
    offer(0, 1'b0);
    wait_kv(0);
    read_exp(0, 4, 64'hFFFD);
    sweep_fwd(0);

    // Reset in GEN cycle 10, then reset colliding with key_valid.
    rand_key(0);
    offer(0, 1'b0);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_gen_busy", 64'(busy[0]), 64'd0);
    chk("rst_gen_kv", 64'(kvo[0]), 64'd0);
    chk("rst_gen_ready", 64'(kready[0]), 64'd1);
    kvalid[0] = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    kvalid[0] = 1'b0;
    chk("rst_wins_busy", 64'(busy[0]), 64'd0);
    rand_key(0);
    offer(0, 1'b0);
    wait_kv(0);
    sweep_fwd(0);

    // Other parameter sets, including z wrap past index 61 on T=72.
    for (int k = 1; k < 3; k++) begin
      rand_key(k);
      offer(k, 1'b0);
      wait_kv(k);
      sweep_fwd(k);
    end

    tick();
    for (int k = 0; k < 3; k++) chk($sformatf("sb_drain inst%0d", k), 64'(sbq[k].size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
